// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the ADC acquisition sequencer:
//   - acq_state_e : sequencer state encoding
//   - ADC_W_DEF   : default ADC sample width
//   - clog2()     : ceil(log2(value)), minimum 1, usable in parameter context
//   - acq_depth() : ring buffer depth derived from pre/post sample counts
// -----------------------------------------------------------------------------
package acq_pkg;

  localparam int ADC_W_DEF = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_ARMED,
    ST_POST,
    ST_READOUT,
    ST_HOLDOFF
  } acq_state_e;

  // Always returns at least 1 so a degenerate size still yields a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int acq_depth(input int pre, input int post);
    return pre + post;
  endfunction

endpackage

// File: rtl/acq_ring_buf.sv
// -----------------------------------------------------------------------------
// acq_ring_buf
// Simple dual-port sample memory: one synchronous write port, one read port
// with a registered output (one cycle read latency). No reset on the array or
// the read register so the tools can map it onto an M10K block.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address, sampled every clock
//   rd_data  out  mem[rd_addr] from the previous clock
// -----------------------------------------------------------------------------
module acq_ring_buf
  import acq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = ADC_W_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/adc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// adc_acq_sequencer
// One acquisition cycle: arm -> pre-trigger fill -> level-crossing trigger ->
// post-trigger capture -> readout of the whole record (oldest sample first)
// over valid/ready -> optional holdoff and automatic re-arm.
// Optional feature macro: ACQ_AUTO_TRIG_EN (adds AUTO_TIMEOUT and auto_trig).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   adc_data, adc_valid  incoming sample and its one-cycle strobe
//   trig_slope           1 = rising crossing, 0 = falling crossing
//   trig_level           crossing threshold (unsigned)
//   arm                  start pulse, honoured only in IDLE
//   continuous           1 = re-arm after holdoff, 0 = single shot
//   out_data/out_valid/out_ready/out_last  record stream
//   busy                 registered (state != IDLE)
//   triggered            one-cycle pulse after the trigger sample is written
//   auto_trig            (ACQ_AUTO_TRIG_EN only) record was force-triggered
// PRE must be at least 1.
// -----------------------------------------------------------------------------
module adc_acq_sequencer
  import acq_pkg::*;
#(
  parameter int ADC_W   = ADC_W_DEF,
  parameter int PRE     = 16,
  parameter int POST    = 48,
  parameter int HOLDOFF = 1000
`ifdef ACQ_AUTO_TRIG_EN
  , parameter int AUTO_TIMEOUT = 5_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic             trig_slope,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             arm,
  input  logic             continuous,
  output logic [ADC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             triggered
`ifdef ACQ_AUTO_TRIG_EN
  , output logic           auto_trig
`endif
);

  localparam int DEPTH = acq_depth(PRE, POST);
  localparam int PTR_W = clog2(DEPTH);
  localparam int HO_W  = clog2(HOLDOFF + 1);

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PRE_LAST  = PTR_W'(PRE - 1);
  localparam logic [PTR_W-1:0] POST_LAST = PTR_W'(POST - 1);
  localparam logic [PTR_W-1:0] PRE_C     = PTR_W'(PRE);
  localparam logic [PTR_W-1:0] BACK_WRAP = PTR_W'(DEPTH - PRE);
  localparam logic [HO_W-1:0]  HO_LAST   = HO_W'(HOLDOFF - 1);

`ifdef ACQ_AUTO_TRIG_EN
  localparam int AT_W = clog2(AUTO_TIMEOUT + 1);
  localparam logic [AT_W-1:0] AT_MAX = AT_W'(AUTO_TIMEOUT);
`endif

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // (p - PRE) mod DEPTH: locates the oldest sample of the record.
  function automatic logic [PTR_W-1:0] ptr_back_pre(input logic [PTR_W-1:0] p);
    return (p >= PRE_C) ? p - PRE_C : p + BACK_WRAP;
  endfunction

  acq_state_e       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic [PTR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
  logic [PTR_W-1:0] out_cnt_q, out_cnt_d;
  logic [HO_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ADC_W-1:0] prev_q, prev_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             trig_pulse_q, trig_pulse_d;
  logic             wr_en;
  logic [ADC_W-1:0] ram_rd_data;
  logic             hit_rise, hit_fall, level_hit, fire;

`ifdef ACQ_AUTO_TRIG_EN
  logic [AT_W-1:0] at_cnt_q, at_cnt_d;
  logic            auto_trig_q, auto_trig_d;
`endif

  // A crossing needs the previous sample on the far side (or on) the level,
  // so a signal already past the threshold on entry never fires.
  assign hit_rise  = (prev_q <= trig_level) && (adc_data > trig_level);
  assign hit_fall  = (prev_q >= trig_level) && (adc_data < trig_level);
  assign level_hit = trig_slope ? hit_rise : hit_fall;
`ifdef ACQ_AUTO_TRIG_EN
  assign fire = level_hit || (at_cnt_q == AT_MAX);
`else
  assign fire = level_hit;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    trig_ptr_d   = trig_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    out_cnt_d    = out_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    prev_d       = prev_q;
    trig_pulse_d = 1'b0;
    wr_en        = 1'b0;
`ifdef ACQ_AUTO_TRIG_EN
    at_cnt_d     = '0;
    auto_trig_d  = auto_trig_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_PREFILL;
          pre_cnt_d = '0;
          wr_ptr_d  = '0;
        end
      end

      ST_PREFILL: begin
`ifdef ACQ_AUTO_TRIG_EN
        auto_trig_d = 1'b0;
`endif
        if (adc_valid) begin
          wr_en     = 1'b1;
          wr_ptr_d  = ptr_inc(wr_ptr_q);
          prev_d    = adc_data;
          pre_cnt_d = pre_cnt_q + PTR_W'(1);
          if (pre_cnt_q == PRE_LAST) state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
`ifdef ACQ_AUTO_TRIG_EN
        at_cnt_d = (at_cnt_q == AT_MAX) ? at_cnt_q : at_cnt_q + AT_W'(1);
`endif
        if (adc_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          prev_d   = adc_data;
          if (fire) begin
            trig_ptr_d   = wr_ptr_q;
            post_cnt_d   = PTR_W'(1);
            trig_pulse_d = 1'b1;
`ifdef ACQ_AUTO_TRIG_EN
            auto_trig_d  = !level_hit;
`endif
            if (POST == 1) begin
              state_d   = ST_READOUT;
              rd_ptr_d  = ptr_back_pre(wr_ptr_q);
              out_cnt_d = '0;
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end

      ST_POST: begin
        if (adc_valid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = ptr_inc(wr_ptr_q);
          prev_d     = adc_data;
          post_cnt_d = post_cnt_q + PTR_W'(1);
          if (post_cnt_q == POST_LAST) begin
            state_d   = ST_READOUT;
            rd_ptr_d  = ptr_back_pre(trig_ptr_q);
            out_cnt_d = '0;
          end
        end
      end

      ST_READOUT: begin
        // Incoming samples are ignored here; only the consumer moves rd_ptr.
        if (out_valid_q && out_ready) begin
          rd_ptr_d  = ptr_inc(rd_ptr_q);
          out_cnt_d = out_cnt_q + PTR_W'(1);
          if (out_cnt_q == LAST_IDX) begin
            state_d    = continuous ? ST_HOLDOFF : ST_IDLE;
            hold_cnt_d = '0;
          end
        end
      end

      ST_HOLDOFF: begin
        if (!continuous) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HO_LAST) begin
          state_d   = ST_PREFILL;
          pre_cnt_d = '0;
          wr_ptr_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_READOUT);
    out_last_d  = out_valid_d && (out_cnt_d == LAST_IDX);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      trig_ptr_q   <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      out_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      prev_q       <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      trig_pulse_q <= 1'b0;
`ifdef ACQ_AUTO_TRIG_EN
      at_cnt_q     <= '0;
      auto_trig_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      trig_ptr_q   <= trig_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      out_cnt_q    <= out_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      prev_q       <= prev_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      trig_pulse_q <= trig_pulse_d;
`ifdef ACQ_AUTO_TRIG_EN
      at_cnt_q     <= at_cnt_d;
      auto_trig_q  <= auto_trig_d;
`endif
    end
  end

  // The read address follows rd_ptr_d, so the registered RAM output already
  // holds mem[rd_ptr_q] each cycle: back-to-back transfers need no bubble and
  // the word stays put while the consumer stalls.
  acq_ring_buf #(
    .DEPTH (DEPTH),
    .W     (ADC_W),
    .AW    (PTR_W)
  ) u_ring_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (adc_data),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  // RAM output has no reset; gate it so out_data reads 0 outside readout.
  assign out_data  = out_valid_q ? ram_rd_data : '0;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign triggered = trig_pulse_q;
`ifdef ACQ_AUTO_TRIG_EN
  assign auto_trig = auto_trig_q;
`endif

endmodule
